branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//  Execute-stage consumer of the fetch-stage predictor outputs (PCPredict/prediction/btbhit).
//  Carries each fetch prediction alongside its instruction through the D and E stages.
//  Compares the prediction with the resolved branch in E and drives misprediction flush/redirect.
//  Emits a one-cycle registered update pulse that feeds the BTB/BHT Branch/PC/PCBranch inputs.
// PARAMETERS
//  XLEN   32  address width
//  CNT_W  32  width of the saturating performance counters
// PORTS
//  Clk          in   1     clock, rising edge
//  Rst          in   1     reset, asynchronous, active-high
//  F_PC         in   XLEN  fetch-stage PC
//  F_Predict    in   1     predictor said taken
//  F_PCPredict  in   XLEN  predicted target; ignored when F_Predict=0
//  F_BtbHit     in   1     BTB hit for F_PC
//  StallD       in   1     F->D pipeline register holds
//  StallE       in   1     D->E pipeline register holds; E does not resolve this cycle
//  E_Branch     in   1     instruction in E is a conditional branch
//  E_Taken      in   1     resolved direction; valid when E_Branch=1
//  E_PCBranch   in   XLEN  resolved taken target; valid when E_Branch=1
//  Mispredict   out  1     combinational; E is resolving a wrong prediction this cycle
//  RedirectPC   out  XLEN  combinational; correct next PC, valid when Mispredict=1
//  FlushD       out  1     = Mispredict
//  FlushE       out  1     = Mispredict
//  UpdValid     out  1     registered one-cycle pulse: predictor update
//  UpdPC        out  XLEN  PC of the resolved branch
//  UpdTarget    out  XLEN  resolved target
//  UpdTaken     out  1     resolved direction
//  BranchCount  out  CNT_W resolved branches, saturating
//  MispredCount out  CNT_W mispredictions, saturating
// BEHAVIOUR
//  Slot = {valid, pc, pred, target, btbhit}. Two slots, SD and SE, mirror the D and E pipeline registers.
//  Rst (async): SD.valid=SE.valid=0, all slot fields 0, UpdValid=0, UpdPC/UpdTarget=0,
//    UpdTaken=0, both counters 0. Comb outputs are then 0 (RedirectPC=0).
//  resolve = SE.valid & ~StallE.
//  Mispredict = resolve & ( (E_Branch & (E_Taken!=SE.pred | (E_Taken & SE.target!=E_PCBranch)))
//               | (~E_Branch & SE.pred) ).  The second term covers an aliased non-branch predicted taken.
//  RedirectPC = (E_Branch & E_Taken) ? E_PCBranch : SE.pc+4, mod 2^XLEN (wraps, no carry out).
//  Slot update each edge, evaluated in priority order:
//   1) Mispredict: SD.valid<=0 and SE.valid<=0, ignoring both stalls.
//   2) Otherwise SE: StallE holds; else if StallD, SE.valid<=0 (bubble); else SE<=SD.
//   3) Otherwise SD: StallD holds; else SD<={1,F_PC,F_Predict,F_PCPredict,F_BtbHit}.
//  Update port, registered: UpdValid<=resolve&E_Branch, UpdPC<=SE.pc, UpdTarget<=E_PCBranch,
//    UpdTaken<=E_Taken. When UpdValid<=0, the Upd* data fields hold their values.
//  UpdValid is exactly one cycle wide per resolved branch, including when StallE was held
//    beforehand, so the downstream edge-triggered update fires once.
//  Counters: BranchCount++ on resolve&E_Branch; MispredCount++ on Mispredict.
//    Both saturate at all-ones and never wrap.
//  Latency: F->resolve is 2 edges minimum; resolve->UpdValid is 1 edge.
// STRUCTURE
//  Shared package: slot field widths/struct, XLEN, PC increment constant 4.
//  One sub-module: pred_slot (slot register with hold/bubble/load/kill controls), instantiated twice.
//  Comparator, redirect mux, update register and counters live in the top level.
// TESTING
//  1) F_PC=0x100,Pred=0; in E: Branch=1,Taken=0 -> Mispredict=0; next cycle UpdValid=1,UpdPC=0x100,UpdTaken=0,BranchCount=1.
//  2) F_PC=0x100,Pred=0; E: Taken=1,PCBranch=0x80 -> Mispredict=1,RedirectPC=0x80; next cycle SD/SE invalid,MispredCount=1.
//  3) Pred=1,PCPredict=0x200; E: Taken=1,PCBranch=0x240 -> Mispredict=1,RedirectPC=0x240,UpdTarget=0x240.
//  4) F_PC=0x104,Pred=1; E: Branch=0 -> Mispredict=1,RedirectPC=0x108; UpdValid stays 0.
//  5) Mispredicting branch in E with StallE=1 for 3 cycles -> Mispredict=0 and UpdValid=0 throughout;
//     on the cycle StallE=0, Mispredict=1; exactly one UpdValid pulse follows.
//  6) StallD=1,StallE=0 -> SE bubble, no resolve next cycle. Rst pulsed mid-stream -> UpdValid and counters 0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the branch-resolve slice: slot layout,
// address width, counter width and the sequential PC increment.
package branch_resolve_pkg;

  localparam int BR_XLEN  = 32;
  localparam int BR_CNT_W = 32;

  // Fall-through distance for a non-taken / non-branch instruction.
  localparam logic [BR_XLEN-1:0] BR_PC_INC = BR_XLEN'(4);

  // One in-flight fetch prediction travelling with its instruction.
  typedef struct packed {
    logic               valid;
    logic [BR_XLEN-1:0] pc;
    logic               pred;
    logic [BR_XLEN-1:0] target;
    logic               btbhit;
  } slot_t;

  localparam slot_t SLOT_RESET = '0;

  function automatic slot_t make_slot(input logic [BR_XLEN-1:0] pc,
                                      input logic               pred,
                                      input logic [BR_XLEN-1:0] target,
                                      input logic               btbhit);
    slot_t s;
    s.valid  = 1'b1;
    s.pc     = pc;
    s.pred   = pred;
    s.target = target;
    s.btbhit = btbhit;
    return s;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bus between the fetch/decode/execute pipeline and the branch-resolve block.
// master = pipeline side, slave = branch_resolve.
interface branch_resolve_if
  import branch_resolve_pkg::*;
#(
  parameter int XLEN  = BR_XLEN,
  parameter int CNT_W = BR_CNT_W
);

  // fetch-stage prediction
  logic             F_PC_valid_unused_placeholder_n;
  logic [XLEN-1:0]  F_PC;
  logic             F_Predict;
  logic [XLEN-1:0]  F_PCPredict;
  logic             F_BtbHit;
  // pipeline control
  logic             StallD;
  logic             StallE;
  // execute-stage resolution
  logic             E_Branch;
  logic             E_Taken;
  logic [XLEN-1:0]  E_PCBranch;
  // flush / redirect
  logic             Mispredict;
  logic [XLEN-1:0]  RedirectPC;
  logic             FlushD;
  logic             FlushE;
  // predictor update port
  logic             UpdValid;
  logic [XLEN-1:0]  UpdPC;
  logic [XLEN-1:0]  UpdTarget;
  logic             UpdTaken;
  // performance counters
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredCount;

  modport master (
    output F_PC, F_Predict, F_PCPredict, F_BtbHit, StallD, StallE,
           E_Branch, E_Taken, E_PCBranch,
    input  Mispredict, RedirectPC, FlushD, FlushE,
           UpdValid, UpdPC, UpdTarget, UpdTaken, BranchCount, MispredCount
  );

  modport slave (
    input  F_PC, F_Predict, F_PCPredict, F_BtbHit, StallD, StallE,
           E_Branch, E_Taken, E_PCBranch,
    output Mispredict, RedirectPC, FlushD, FlushE,
           UpdValid, UpdPC, UpdTarget, UpdTaken, BranchCount, MispredCount
  );

endinterface

// File: rtl/branch_resolve_pred_slot.sv
// One prediction slot register mirroring a pipeline register.
// Priority: kill (valid cleared) > hold > bubble (valid cleared) > load.
// Kill and bubble only drop valid; the payload fields keep their old values.
module branch_resolve_pred_slot
  import branch_resolve_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  kill_i,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  slot_t load_i,
  output slot_t slot_o
);

  slot_t slot_q, slot_d;

  // Next-slot selection by control priority.
  always_comb begin
    slot_d = slot_q;
    if (kill_i) begin
      slot_d.valid = 1'b0;
    end else if (!hold_i) begin
      if (bubble_i) begin
        slot_d.valid = 1'b0;
      end else begin
        slot_d = load_i;
      end
    end
  end

  // Slot register, cleared asynchronously.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      slot_q <= SLOT_RESET;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: carries fetch predictions through D and E,
// detects mispredictions, drives flush/redirect, emits a registered predictor
// update pulse and keeps saturating branch/mispredict counters.
// The slot struct is sized by BR_XLEN, so XLEN must stay equal to BR_XLEN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN  = BR_XLEN,
  parameter int CNT_W = BR_CNT_W
) (
  input logic             Clk,
  input logic             Rst,
  branch_resolve_if.slave bus
);

  slot_t            sd_q, se_q, sd_load;
  logic             resolve, mispredict, upd_fire;
  logic             dir_wrong, tgt_wrong;
  logic [XLEN-1:0]  redirect_pc;
  logic             upd_valid_q;
  logic [XLEN-1:0]  upd_pc_q, upd_target_q;
  logic             upd_taken_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
  // BTB hit travels with the slot for downstream consumers; nothing here reads it.
  logic             unused_btbhit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign sd_load       = make_slot(bus.F_PC, bus.F_Predict, bus.F_PCPredict, bus.F_BtbHit);
  assign unused_btbhit = se_q.btbhit;

  // D slot: loads from fetch unless D stalls; killed on mispredict.
  branch_resolve_pred_slot u_slot_d (
    .Clk      (Clk),
    .Rst      (Rst),
    .kill_i   (mispredict),
    .hold_i   (bus.StallD),
    .bubble_i (1'b0),
    .load_i   (sd_load),
    .slot_o   (sd_q)
  );

  // E slot: takes D's slot, or a bubble when D stalls but E advances.
  branch_resolve_pred_slot u_slot_e (
    .Clk      (Clk),
    .Rst      (Rst),
    .kill_i   (mispredict),
    .hold_i   (bus.StallE),
    .bubble_i (bus.StallD),
    .load_i   (sd_q),
    .slot_o   (se_q)
  );

  // Compare the carried prediction against the resolved outcome in E.
  always_comb begin
    resolve    = se_q.valid & ~bus.StallE;
    dir_wrong  = bus.E_Taken != se_q.pred;
    tgt_wrong  = bus.E_Taken & (se_q.target != bus.E_PCBranch);
    // A non-branch that was predicted taken is an aliased BTB hit: redirect it.
    mispredict = resolve & (bus.E_Branch ? (dir_wrong | tgt_wrong) : se_q.pred);
    upd_fire   = resolve & bus.E_Branch;
  end

  // Correct next PC; forced to zero whenever there is no mispredict.
  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = (bus.E_Branch & bus.E_Taken) ? bus.E_PCBranch : se_q.pc + BR_PC_INC;
    end
  end

  // Predictor update register: one pulse per resolved branch, data held otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      upd_valid_q <= upd_fire;
      if (upd_fire) begin
        upd_pc_q     <= se_q.pc;
        upd_target_q <= bus.E_PCBranch;
        upd_taken_q  <= bus.E_Taken;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_fire)   branch_cnt_q  <= sat_inc(branch_cnt_q);
      if (mispredict) mispred_cnt_q <= sat_inc(mispred_cnt_q);
    end
  end

  assign bus.Mispredict   = mispredict;
  assign bus.RedirectPC   = redirect_pc;
  assign bus.FlushD       = mispredict;
  assign bus.FlushE       = mispredict;
  assign bus.UpdValid     = upd_valid_q;
  assign bus.UpdPC        = upd_pc_q;
  assign bus.UpdTarget    = upd_target_q;
  assign bus.UpdTaken     = upd_taken_q;
  assign bus.BranchCount  = branch_cnt_q;
  assign bus.MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a reference model of the D/E slots tracks every
// cycle, expected updates are queued when a branch resolves and compared when
// UpdValid appears. Directed scenarios add fixed-value checks.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;   // narrow so saturation is reached quickly

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) br ();

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (br.slave)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            tk;
  } upd_t;

  upd_t sb[$];

  int nchk = 0;
  int nbad = 0;

  // reference state
  logic            m_sd_v, m_se_v, m_sd_pred, m_se_pred, m_upd_v;
  logic [XLEN-1:0] m_sd_pc, m_sd_tgt, m_se_pc, m_se_tgt;
  logic [CNT_W-1:0] m_bcnt, m_mcnt;
  logic            exp_res, exp_mis;
  logic [XLEN-1:0] exp_redir;
  int              pulses;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sd_v = 0; m_se_v = 0; m_sd_pred = 0; m_se_pred = 0; m_upd_v = 0;
    m_sd_pc = 0; m_sd_tgt = 0; m_se_pc = 0; m_se_tgt = 0;
    m_bcnt = 0; m_mcnt = 0;
    sb.delete();
  endtask

  task automatic drive(input logic [XLEN-1:0] fpc, input logic fp, input logic [XLEN-1:0] fpp,
                       input logic sd, input logic se, input logic eb, input logic et,
                       input logic [XLEN-1:0] epb);
    br.F_PC = fpc; br.F_Predict = fp; br.F_PCPredict = fpp; br.F_BtbHit = fp;
    br.StallD = sd; br.StallE = se;
    br.E_Branch = eb; br.E_Taken = et; br.E_PCBranch = epb;
  endtask

  // Called mid-cycle (negedge): compare comb outputs and registered state with the model.
  task automatic eval_check();
    upd_t u;
    exp_res = m_se_v && !br.StallE;
    if (!exp_res)          exp_mis = 1'b0;
    else if (br.E_Branch)  exp_mis = br.E_Taken ? (!m_se_pred || (m_se_tgt != br.E_PCBranch)) : m_se_pred;
    else                   exp_mis = m_se_pred;
    if (!exp_mis)                      exp_redir = '0;
    else if (br.E_Branch && br.E_Taken) exp_redir = br.E_PCBranch;
    else                               exp_redir = m_se_pc + 32'd4;
    chk("mispredict", br.Mispredict, exp_mis);
    chk("redirect",   br.RedirectPC, exp_redir);
    chk("flushd",     br.FlushD,     exp_mis);
    chk("flushe",     br.FlushE,     exp_mis);
    chk("updvalid",   br.UpdValid,   m_upd_v);
    chk("brcount",    br.BranchCount,  m_bcnt);
    chk("mpcount",    br.MispredCount, m_mcnt);
    if (br.UpdValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        u = sb.pop_front();
        chk("updpc",    br.UpdPC,     u.pc);
        chk("updtgt",   br.UpdTarget, u.tgt);
        chk("updtaken", br.UpdTaken,  u.tk);
      end
    end
    if (exp_res && br.E_Branch) begin
      u.pc = m_se_pc; u.tgt = br.E_PCBranch; u.tk = br.E_Taken;
      sb.push_back(u);
    end
  endtask

  // Step the model across the rising edge, then move to the drive point.
  task automatic advance();
    @(posedge Clk);
    m_upd_v = exp_res && br.E_Branch;
    if (m_upd_v && m_bcnt != '1) m_bcnt = m_bcnt + 1'b1;
    if (exp_mis && m_mcnt != '1) m_mcnt = m_mcnt + 1'b1;
    if (exp_mis) begin
      m_sd_v = 0; m_se_v = 0;
    end else begin
      if (!br.StallE) begin
        if (br.StallD) m_se_v = 0;
        else begin
          m_se_v = m_sd_v; m_se_pc = m_sd_pc; m_se_pred = m_sd_pred; m_se_tgt = m_sd_tgt;
        end
      end
      if (!br.StallD) begin
        m_sd_v = 1; m_sd_pc = br.F_PC; m_sd_pred = br.F_Predict; m_sd_tgt = br.F_PCPredict;
      end
    end
    #1;
  endtask

  task automatic half(input logic [XLEN-1:0] fpc, input logic fp, input logic [XLEN-1:0] fpp,
                      input logic sd, input logic se, input logic eb, input logic et,
                      input logic [XLEN-1:0] epb);
    drive(fpc, fp, fpp, sd, se, eb, et, epb);
    @(negedge Clk);
    eval_check();
  endtask

  task automatic cyc(input logic [XLEN-1:0] fpc, input logic fp, input logic [XLEN-1:0] fpp,
                     input logic sd, input logic se, input logic eb, input logic et,
                     input logic [XLEN-1:0] epb);
    half(fpc, fp, fpp, sd, se, eb, et, epb);
    advance();
  endtask

  initial begin
    logic [XLEN-1:0] tset [4];
    tset[0] = 32'h2000; tset[1] = 32'h2004; tset[2] = 32'h0; tset[3] = 32'h2008;

    Rst = 1'b1;
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    model_reset();
    @(posedge Clk); #1;
    chk("rst_updvalid", br.UpdValid, 0);
    chk("rst_updpc",    br.UpdPC, 0);
    chk("rst_updtgt",   br.UpdTarget, 0);
    chk("rst_updtaken", br.UpdTaken, 0);
    chk("rst_brcount",  br.BranchCount, 0);
    chk("rst_mpcount",  br.MispredCount, 0);
    chk("rst_mispred",  br.Mispredict, 0);
    chk("rst_redirect", br.RedirectPC, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Correctly predicted not-taken branch
    cyc (32'h100, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc (32'h104, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    half(32'h108, 0, 32'h0, 0, 0, 1, 0, 32'h0);
    chk("t1_mispred", br.Mispredict, 0);
    advance();
    half(32'h10c, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t1_updvalid", br.UpdValid, 1);
    chk("t1_updpc",    br.UpdPC, 32'h100);
    chk("t1_updtaken", br.UpdTaken, 0);
    chk("t1_brcount",  br.BranchCount, 1);
    advance();

    // Predicted not-taken, actually taken
    cyc (32'h100, 0, 32'h0,   0, 0, 0, 0, 32'h0);
    cyc (32'h1f0, 1, 32'h200, 0, 0, 0, 0, 32'h0);
    half(32'h300, 0, 32'h0,   0, 0, 1, 1, 32'h80);
    chk("t2_mispred",  br.Mispredict, 1);
    chk("t2_redirect", br.RedirectPC, 32'h80);
    advance();
    half(32'h1f0, 1, 32'h200, 0, 0, 0, 0, 32'h0);
    chk("t2_mispred_after", br.Mispredict, 0);
    chk("t2_mpcount",       br.MispredCount, 1);
    advance();

    // Taken as predicted but to a different target
    cyc (32'h104, 1, 32'h999, 0, 0, 0, 0, 32'h0);
    half(32'h400, 0, 32'h0,   0, 0, 1, 1, 32'h240);
    chk("t3_mispred",  br.Mispredict, 1);
    chk("t3_redirect", br.RedirectPC, 32'h240);
    advance();
    half(32'h104, 1, 32'h500, 0, 0, 0, 0, 32'h0);
    chk("t3_updtgt",   br.UpdTarget, 32'h240);
    chk("t3_updtaken", br.UpdTaken, 1);
    chk("t3_updpc",    br.UpdPC, 32'h1f0);
    advance();

    // Non-branch predicted taken
    cyc (32'h500, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    half(32'h600, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t4_mispred",  br.Mispredict, 1);
    chk("t4_redirect", br.RedirectPC, 32'h108);
    advance();
    half(32'h700, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t4_updvalid", br.UpdValid, 0);
    advance();

    // Mispredicting branch held in E for three cycles
    cyc(32'h704, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      half(32'h708, 0, 32'h0, 1, 1, 1, 1, 32'h900);
      chk("t5_stall_mis", br.Mispredict, 0);
      chk("t5_stall_upd", br.UpdValid, 0);
      advance();
    end
    half(32'h708, 0, 32'h0, 0, 0, 1, 1, 32'h900);
    chk("t5_mispred",  br.Mispredict, 1);
    chk("t5_redirect", br.RedirectPC, 32'h900);
    advance();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      half(32'h800, 0, 32'h0, 0, 0, 0, 0, 32'h0);
      if (br.UpdValid === 1'b1) pulses++;
      advance();
    end
    chk("t5_pulses", pulses, 1);

    // Bubble into E when D stalls alone
    cyc (32'ha00, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc (32'ha04, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc (32'ha08, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    half(32'ha0c, 0, 32'h0, 0, 0, 1, 1, 32'h123);
    chk("t6_bubble_mis", br.Mispredict, 0);
    advance();
    half(32'ha10, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t6_bubble_upd", br.UpdValid, 0);
    advance();

    // Asynchronous reset mid-stream
    cyc (32'hb00, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc (32'hb04, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc (32'hb08, 0, 32'h0, 0, 0, 1, 0, 32'h0);
    chk("t6_pre_upd", br.UpdValid, 1);
    #2;
    Rst = 1'b1;
    #1;
    chk("t6_rst_upd",     br.UpdValid, 0);
    chk("t6_rst_brcount", br.BranchCount, 0);
    chk("t6_rst_mpcount", br.MispredCount, 0);
    chk("t6_rst_mispred", br.Mispredict, 0);
    chk("t6_rst_redir",   br.RedirectPC, 0);
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b0;

    // PC increment wraps at the top of the address space
    cyc (32'hffff_fffc, 1, 32'h10, 0, 0, 0, 0, 32'h0);
    cyc (32'h0,         0, 32'h0,  0, 0, 0, 0, 32'h0);
    half(32'h4,         0, 32'h0,  0, 0, 0, 0, 32'h0);
    chk("wrap_mispred",  br.Mispredict, 1);
    chk("wrap_redirect", br.RedirectPC, 32'h0);
    advance();

    // Random traffic, long enough to saturate both counters
    for (int i = 0; i < 300; i++) begin
      cyc(32'h1000 + 32'($urandom_range(0, 15)) * 4,
          1'($urandom_range(0, 1)),
          tset[$urandom_range(0, 3)],
          ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 1)),
          tset[$urandom_range(0, 3)]);
    end
    half(32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("sat_brcount", br.BranchCount, 4'hf);
    chk("sat_mpcount", br.MispredCount, 4'hf);
    advance();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
